load_store_unit: RTL and testbench

- Sits between the execute stage and the data memory; owns every memory access the core makes.
- Naturally aligned accesses go to the memory as one access of the requested size.
- Misaligned halfword/word accesses are split into sequential byte accesses. Split loads are reassembled and extended here; split stores are scattered into byte writes.
- Stalls the pipeline with `req_ready` while busy.

---
 rtl/load_store_unit_pkg.sv | 37 +++
 rtl/load_store_unit_if.sv | 38 +++
 rtl/lsu_load_extend.sv | 22 ++
 rtl/load_store_unit.sv | 124 ++++++++++++
 tb/tb_load_store_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM encoding, alignment helpers.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package load_store_unit_pkg;

   // funct3 access-size encodings shared with the data memory
   localparam logic [2:0] SZ_B  = 3'b000;
   localparam logic [2:0] SZ_H  = 3'b001;
   localparam logic [2:0] SZ_W  = 3'b010;
   localparam logic [2:0] SZ_BU = 3'b100;
   localparam logic [2:0] SZ_HU = 3'b101;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   // Only the five load/store funct3 codes are meaningful; 011/110/111 are rejected.
   function automatic logic size_legal(input logic [2:0] size);
      return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) ||
             (size == SZ_BU) || (size == SZ_HU);
   endfunction

   // Byte accesses can never be misaligned; halves need addr[0]=0, words addr[1:0]=0.
   function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (size)
         SZ_H, SZ_HU: mis = addr_lo[0];
         SZ_W:        mis = (addr_lo != 2'b00);
         default:     mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// Latency: none (wires only).
// Backpressure: req_ready from the LSU; the master holds a request until accepted.
interface load_store_unit_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [2:0]        req_size;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;

   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;

   logic [31:0]       mem_access_addr;
   logic [31:0]       mem_wr_val;
   logic              mem_write_en;
   logic              mem_read_en;
   logic [2:0]        mem_data_size;
   logic [31:0]       mem_rd_val;

   // Requester plus data memory side
   modport master (
      output req_valid, req_write, req_size, req_addr, req_wdata, mem_rd_val,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_access_addr, mem_wr_val, mem_write_en, mem_read_en, mem_data_size
   );

   // Load/store unit side
   modport slave (
      input  req_valid, req_write, req_size, req_addr, req_wdata, mem_rd_val,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_access_addr, mem_wr_val, mem_write_en, mem_read_en, mem_data_size
   );
endinterface

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of a byte-assembled split load according to its funct3 size.
// Latency: combinational.
// Backpressure: none.
module lsu_load_extend
   import load_store_unit_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [31:0] din,
   output logic [31:0] dout
);

   // Split loads are only ever halves or words; words are already full width.
   always_comb begin
      dout = din;
      case (size)
         SZ_H:    dout = {{16{din[15]}}, din[15:0]};
         SZ_HU:   dout = {16'h0000, din[15:0]};
         default: dout = din;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: issues core data accesses, splitting misaligned half/word accesses into bytes.
// Latency accept->resp_valid: aligned 1, split half 2, split word 4, rejected request 0 cycles.
// Backpressure: req_ready high only in IDLE; requests offered while busy are held by the requester.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter bit ALLOW_MISALIGNED = 1'b1,
   parameter int ADDR_W           = 32
) (
   input logic              clk,
   input logic              reset,
   load_store_unit_if.slave bus
);

   logic [1:0]        state_q;
   logic              write_q;
   logic [2:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              split_q;
   logic [1:0]        byte_cnt_q;
   logic [31:0]       asm_q;

   logic              accept;
   logic              req_legal;
   logic              req_mis;
   logic              last_byte;
   logic [ADDR_W-1:0] byte_addr;
   logic [7:0]        wr_byte;
   logic [31:0]       ext_val;

   assign bus.req_ready = (state_q == ST_IDLE);
   assign accept        = bus.req_valid && (state_q == ST_IDLE);
   assign req_legal     = size_legal(bus.req_size);
   assign req_mis       = misaligned(bus.req_size, bus.req_addr[1:0]);

   // Aligned accesses are one beat; split halves take 2 byte beats, split words 4.
   assign last_byte = !split_q || (byte_cnt_q == ((size_q == SZ_W) ? 2'd3 : 2'd1));
   // Byte address wraps naturally at the address width.
   assign byte_addr = addr_q + ADDR_W'(byte_cnt_q);
   assign wr_byte   = wdata_q[{byte_cnt_q, 3'b000} +: 8];

   lsu_load_extend u_load_extend (
      .size (size_q),
      .din  (asm_q),
      .dout (ext_val)
   );

   // Request latch, byte sequencing, load assembly and FSM transitions.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         write_q    <= 1'b0;
         size_q     <= 3'b000;
         addr_q     <= '0;
         wdata_q    <= 32'h0;
         split_q    <= 1'b0;
         byte_cnt_q <= 2'd0;
         asm_q      <= 32'h0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  write_q    <= bus.req_write;
                  size_q     <= bus.req_size;
                  addr_q     <= bus.req_addr;
                  wdata_q    <= bus.req_wdata;
                  split_q    <= req_mis;
                  byte_cnt_q <= 2'd0;
                  asm_q      <= 32'h0;
                  if (!req_legal || (req_mis && !ALLOW_MISALIGNED))
                     state_q <= ST_ERR;
                  else
                     state_q <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (!write_q) begin
                  if (split_q)
                     asm_q[{byte_cnt_q, 3'b000} +: 8] <= bus.mem_rd_val[7:0];
                  else
                     asm_q <= bus.mem_rd_val;
               end
               if (last_byte) begin
                  byte_cnt_q <= 2'd0;
                  state_q    <= ST_RESP;
               end else begin
                  byte_cnt_q <= byte_cnt_q + 2'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.resp_valid = (state_q == ST_RESP) || (state_q == ST_ERR);
   assign bus.resp_err   = (state_q == ST_ERR);
   assign bus.resp_rdata = ((state_q == ST_RESP) && !write_q) ?
                           (split_q ? ext_val : asm_q) : 32'h0;

   // Memory drive: only in XFER, and suppressed during a reset cycle so an
   // interrupted split store commits no further bytes.
   always_comb begin
      bus.mem_access_addr = 32'h0;
      bus.mem_wr_val      = 32'h0;
      bus.mem_write_en    = 1'b0;
      bus.mem_read_en     = 1'b0;
      bus.mem_data_size   = 3'b000;
      if ((state_q == ST_XFER) && !reset) begin
         bus.mem_read_en  = !write_q;
         bus.mem_write_en = write_q;
         if (split_q) begin
            bus.mem_access_addr = 32'(byte_addr);
            bus.mem_data_size   = write_q ? SZ_B : SZ_BU;
            bus.mem_wr_val      = write_q ? {24'h0, wr_byte} : 32'h0;
         end else begin
            bus.mem_access_addr = 32'(addr_q);
            bus.mem_data_size   = size_q;
            bus.mem_wr_val      = wdata_q;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one DUT splitting misaligned accesses, one rejecting them.
// Latency: checks accept-to-response cycle counts against hand-derived values.
// Backpressure: verifies req_ready stays low while busy and returns high after the response.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel_b;
   logic        req_valid;
   logic        req_write;
   logic [2:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        do_preload;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  mem [16];
   logic [3:0]  ma;
   logic [7:0]  mb0, mb1, mb2, mb3;
   logic [31:0] mem_rd;
   logic [31:0] acc_addr [$];

   load_store_unit_if #(.ADDR_W(32)) bus_a ();
   load_store_unit_if #(.ADDR_W(32)) bus_b ();

   load_store_unit #(.ALLOW_MISALIGNED(1'b1), .ADDR_W(32)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   load_store_unit #(.ALLOW_MISALIGNED(1'b0), .ADDR_W(32)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   always #5 clk = ~clk;

   assign bus_a.req_valid  = req_valid && !sel_b;
   assign bus_a.req_write  = req_write;
   assign bus_a.req_size   = req_size;
   assign bus_a.req_addr   = req_addr;
   assign bus_a.req_wdata  = req_wdata;
   assign bus_a.mem_rd_val = mem_rd;

   assign bus_b.req_valid  = req_valid && sel_b;
   assign bus_b.req_write  = req_write;
   assign bus_b.req_size   = req_size;
   assign bus_b.req_addr   = req_addr;
   assign bus_b.req_wdata  = req_wdata;
   assign bus_b.mem_rd_val = 32'h0;

   logic        m_req_ready, m_resp_valid, m_resp_err, m_rd_en, m_wr_en;
   logic [31:0] m_resp_rdata, m_addr;
   logic [2:0]  m_size;
   assign m_req_ready  = sel_b ? bus_b.req_ready       : bus_a.req_ready;
   assign m_resp_valid = sel_b ? bus_b.resp_valid      : bus_a.resp_valid;
   assign m_resp_err   = sel_b ? bus_b.resp_err        : bus_a.resp_err;
   assign m_resp_rdata = sel_b ? bus_b.resp_rdata      : bus_a.resp_rdata;
   assign m_rd_en      = sel_b ? bus_b.mem_read_en     : bus_a.mem_read_en;
   assign m_wr_en      = sel_b ? bus_b.mem_write_en    : bus_a.mem_write_en;
   assign m_addr       = sel_b ? bus_b.mem_access_addr : bus_a.mem_access_addr;
   assign m_size       = sel_b ? bus_b.mem_data_size   : bus_a.mem_data_size;

   // Combinational data memory read for DUT A, extending by the requested size.
   always_comb begin
      ma  = bus_a.mem_access_addr[3:0];
      mb0 = mem[ma];
      mb1 = mem[ma + 4'd1];
      mb2 = mem[ma + 4'd2];
      mb3 = mem[ma + 4'd3];
      case (bus_a.mem_data_size)
         3'b000:  mem_rd = {{24{mb0[7]}}, mb0};
         3'b100:  mem_rd = {24'h0, mb0};
         3'b001:  mem_rd = {{16{mb1[7]}}, mb1, mb0};
         3'b101:  mem_rd = {16'h0, mb1, mb0};
         default: mem_rd = {mb3, mb2, mb1, mb0};
      endcase
   end

   // Data memory writes for DUT A, plus the preload image.
   always @(posedge clk) begin
      if (do_preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
         mem[0] <= 8'h11; mem[1] <= 8'h22; mem[2] <= 8'h33; mem[3] <= 8'h44;
         mem[4] <= 8'hF5; mem[5] <= 8'h66; mem[6] <= 8'h77; mem[7] <= 8'h88;
      end else if (bus_a.mem_write_en) begin
         mem[bus_a.mem_access_addr[3:0]] <= bus_a.mem_wr_val[7:0];
         if (bus_a.mem_data_size == 3'b001 || bus_a.mem_data_size == 3'b010)
            mem[bus_a.mem_access_addr[3:0] + 4'd1] <= bus_a.mem_wr_val[15:8];
         if (bus_a.mem_data_size == 3'b010) begin
            mem[bus_a.mem_access_addr[3:0] + 4'd2] <= bus_a.mem_wr_val[23:16];
            mem[bus_a.mem_access_addr[3:0] + 4'd3] <= bus_a.mem_wr_val[31:24];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic preload();
      @(negedge clk);
      do_preload = 1'b1;
      @(posedge clk);
      #1 do_preload = 1'b0;
   endtask

   task automatic do_req(input bit on_b, input bit wr, input logic [2:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int nrd, output int nwr, output logic [2:0] fsz,
                         output logic excl_bad, output logic rdy_bad);
      lat = -1; rdata = 32'hDEAD_BEEF; err = 1'bx; nrd = 0; nwr = 0;
      fsz = 3'b111; excl_bad = 1'b0; rdy_bad = 1'b0;
      acc_addr.delete();
      @(negedge clk);
      sel_b = on_b; req_write = wr; req_size = sz; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (m_rd_en) nrd++;
         if (m_wr_en) nwr++;
         if (m_rd_en && m_wr_en) excl_bad = 1'b1;
         if (m_rd_en || m_wr_en) begin
            if (acc_addr.size() == 0) fsz = m_size;
            acc_addr.push_back(m_addr);
         end
         if (m_resp_valid) begin
            lat = c; rdata = m_resp_rdata; err = m_resp_err;
            break;
         end
         if (m_req_ready) rdy_bad = 1'b1;
      end
   endtask

   task automatic run(input string tag, input bit on_b, input bit wr, input logic [2:0] sz,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input int exp_lat, input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_nrd, input int exp_nwr, input logic [2:0] exp_sz);
      int lat, nrd, nwr;
      logic [31:0] rd;
      logic err, excl_bad, rdy_bad;
      logic [2:0] fsz;
      do_req(on_b, wr, sz, addr, wd, lat, rd, err, nrd, nwr, fsz, excl_bad, rdy_bad);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " rdata"}, rd, exp_rd);
      check({tag, " err"}, 32'(err), 32'(exp_err));
      check({tag, " reads"}, 32'(nrd), 32'(exp_nrd));
      check({tag, " writes"}, 32'(nwr), 32'(exp_nwr));
      check({tag, " rd_wr_both"}, 32'(excl_bad), 32'd0);
      check({tag, " ready_busy"}, 32'(rdy_bad), 32'd0);
      if (exp_nrd + exp_nwr > 0) check({tag, " mem_size"}, 32'(fsz), 32'(exp_sz));
      @(negedge clk);
      check({tag, " ready_after"}, 32'(m_req_ready), 32'd1);
   endtask

   initial begin
      int nwr, nresp;
      reset = 1'b1; sel_b = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_size = 3'b000; req_addr = 32'h0; req_wdata = 32'h0; do_preload = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0; do_preload = 1'b0;

      // reset state
      check("rst req_ready", 32'(bus_a.req_ready), 32'd1);
      check("rst resp_valid", 32'(bus_a.resp_valid), 32'd0);
      check("rst resp_err", 32'(bus_a.resp_err), 32'd0);
      check("rst resp_rdata", bus_a.resp_rdata, 32'h0);
      check("rst mem_en", {30'h0, bus_a.mem_read_en, bus_a.mem_write_en}, 32'h0);
      check("rst mem_addr", bus_a.mem_access_addr, 32'h0);

      // aligned loads
      run("lw@4",  0, 0, SZ_W,  32'h4, 0, 1, 32'h887766F5, 0, 1, 0, SZ_W);
      run("lb@4",  0, 0, SZ_B,  32'h4, 0, 1, 32'hFFFFFFF5, 0, 1, 0, SZ_B);
      run("lhu@6", 0, 0, SZ_HU, 32'h6, 0, 1, 32'h00008877, 0, 1, 0, SZ_HU);

      // split loads
      run("lw@1", 0, 0, SZ_W, 32'h1, 0, 4, 32'hF5443322, 0, 4, 0, SZ_BU);
      check("lw@1 addr0", acc_addr.size() > 0 ? acc_addr[0] : 32'hX, 32'h1);
      check("lw@1 addr3", acc_addr.size() > 3 ? acc_addr[3] : 32'hX, 32'h4);
      run("lh@3",  0, 0, SZ_H,  32'h3, 0, 2, 32'hFFFFF544, 0, 2, 0, SZ_BU);
      run("lhu@3", 0, 0, SZ_HU, 32'h3, 0, 2, 32'h0000F544, 0, 2, 0, SZ_BU);

      // address wrap on a split word
      run("lw@wrap", 0, 0, SZ_W, 32'hFFFFFFFF, 0, 4, 32'h33221100, 0, 4, 0, SZ_BU);
      check("wrap addr1", acc_addr.size() > 1 ? acc_addr[1] : 32'hX, 32'h0);

      // split store
      run("sw@2", 0, 1, SZ_W, 32'h2, 32'hAABBCCDD, 4, 32'h0, 0, 0, 4, SZ_B);
      check("sw@2 word0", {mem[3], mem[2], mem[1], mem[0]}, 32'hCCDD2211);
      check("sw@2 word1", {mem[7], mem[6], mem[5], mem[4]}, 32'h8877AABB);

      // aligned half store
      run("sh@8", 0, 1, SZ_H, 32'h8, 32'h1234BEEF, 1, 32'h0, 0, 0, 1, SZ_H);
      check("sh@8 word2", {mem[11], mem[10], mem[9], mem[8]}, 32'h0000BEEF);

      // reset during a split store after two byte writes
      preload();
      nwr = 0; nresp = 0;
      @(negedge clk);
      sel_b = 1'b0; req_write = 1'b1; req_size = SZ_W; req_addr = 32'h2;
      req_wdata = 32'hAABBCCDD; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (m_wr_en) nwr++;
         if (m_resp_valid) nresp++;
      end
      @(negedge clk);
      reset = 1'b1;
      #1 check("rst_mid wr_en", 32'(m_wr_en), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      check("rst_mid ready", 32'(m_req_ready), 32'd1);
      check("rst_mid resp", 32'(m_resp_valid), 32'd0);
      repeat (6) begin
         @(negedge clk);
         if (m_resp_valid) nresp++;
      end
      check("rst_mid writes", 32'(nwr), 32'd2);
      check("rst_mid no_resp", 32'(nresp), 32'd0);
      check("rst_mid word0", {mem[3], mem[2], mem[1], mem[0]}, 32'hCCDD2211);
      check("rst_mid word1", {mem[7], mem[6], mem[5], mem[4]}, 32'h887766F5);

      // illegal sizes
      run("size011", 0, 0, 3'b011, 32'h0, 0, 0, 32'h0, 1, 0, 0, 3'b000);
      run("size110", 0, 1, 3'b110, 32'h4, 32'h55, 0, 32'h0, 1, 0, 0, 3'b000);

      // misaligned rejection on the non-splitting instance
      run("B lw@1", 1, 0, SZ_W, 32'h1, 0, 0, 32'h0, 1, 0, 0, 3'b000);
      run("B sh@3", 1, 1, SZ_H, 32'h3, 32'h77, 0, 32'h0, 1, 0, 0, 3'b000);
      run("B lw@4", 1, 0, SZ_W, 32'h4, 0, 1, 32'h0, 0, 1, 0, SZ_W);
      run("B lb@3", 1, 0, SZ_B, 32'h3, 0, 1, 32'h0, 0, 1, 0, SZ_B);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
